// File: rtl/skid_buffer.sv
// Two-entry valid/ready register slice. The upstream ready is a flop, so no
// combinational path runs from out_ready back to in_ready.
module skid_buffer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_ONE   = 2'd1;
    localparam logic [1:0] OCC_FULL  = 2'd2;

    logic [1:0]       occ_reg;
    logic [1:0]       occ_next;
    logic [WIDTH-1:0] head_reg;
    logic [WIDTH-1:0] head_next;
    logic [WIDTH-1:0] skid_reg;
    logic [WIDTH-1:0] skid_next;
    logic             ready_reg;
    logic             push;
    logic             take;

    assign push = in_valid && ready_reg;
    assign take = (occ_reg != OCC_EMPTY) && out_ready;

    always_comb begin
        occ_next  = occ_reg;
        head_next = head_reg;
        skid_next = skid_reg;
        case (occ_reg)
            OCC_EMPTY: begin
                if (push) begin
                    head_next = in_data;
                    occ_next  = OCC_ONE;
                end
            end
            OCC_ONE: begin
                if (push && !take) begin
                    skid_next = in_data;
                    occ_next  = OCC_FULL;
                end else if (push && take) begin
                    head_next = in_data;
                end else if (take) begin
                    occ_next = OCC_EMPTY;
                end
            end
            OCC_FULL: begin
                // No push is possible here because ready_reg is low.
                if (take) begin
                    head_next = skid_reg;
                    occ_next  = OCC_ONE;
                end
            end
            default: begin
                occ_next = OCC_EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            occ_reg   <= OCC_EMPTY;
            head_reg  <= '0;
            skid_reg  <= '0;
            ready_reg <= 1'b1;
        end else begin
            occ_reg   <= occ_next;
            head_reg  <= head_next;
            skid_reg  <= skid_next;
            ready_reg <= (occ_next != OCC_FULL);
        end
    end

    assign in_ready  = ready_reg;
    assign out_valid = (occ_reg != OCC_EMPTY);
    assign out_data  = head_reg;

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains a first-word-fall-through FIFO into a registered valid/ready stream
// and counts delivered words.
module fifo_stream_reader #(
    parameter int DATA_WIDTH  = 8,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   fifo_empty,
    input  logic [DATA_WIDTH-1:0]  fifo_read_data,
    output logic                   fifo_read_en,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_WIDTH-1:0]  out_data,
    output logic [COUNT_WIDTH-1:0] word_count
);

    logic                   buf_ready;
    logic                   buf_in_valid;
    logic [COUNT_WIDTH-1:0] count_reg;

    // Gating with reset keeps the pop strobe low for the whole reset window.
    assign buf_in_valid = reset && !fifo_empty;
    assign fifo_read_en = buf_in_valid && buf_ready;

    skid_buffer #(
        .WIDTH(DATA_WIDTH)
    ) u_skid (
        .clk      (clk),
        .reset    (reset),
        .in_valid (buf_in_valid),
        .in_ready (buf_ready),
        .in_data  (fifo_read_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_reg <= '0;
        end else if (out_valid && out_ready) begin
            count_reg <= count_reg + COUNT_WIDTH'(1);
        end
    end

    assign word_count = count_reg;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: behavioural FWFT FIFO, scoreboard on every
// stream transfer, a step table for the basic state walk, and scenario runs.
module tb_fifo_stream_reader;

    localparam int DW    = 8;
    localparam int CW    = 16;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          fifo_empty;
    logic [DW-1:0] fifo_read_data;
    logic          fifo_read_en;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [CW-1:0] word_count;

    always #5 clk = ~clk;

    fifo_stream_reader #(
        .DATA_WIDTH (DW),
        .COUNT_WIDTH(CW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .fifo_empty    (fifo_empty),
        .fifo_read_data(fifo_read_data),
        .fifo_read_en  (fifo_read_en),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .word_count    (word_count)
    );

    int n_vec = 0;
    int n_bad = 0;

    // Requests from the main sequence to the FIFO model.
    logic          wr_en;
    logic [DW-1:0] wr_data;
    int            clear_seq;
    int            gen_seq;
    logic [DW-1:0] gen_start;
    int            gen_len;
    int            drop_total;

    // FIFO model and scoreboard state.
    logic [DW-1:0] mem [DEPTH];
    logic [3:0]    rp  = '0;
    logic [3:0]    wp  = '0;
    logic [4:0]    cnt = '0;
    logic [DW-1:0] exp_q [$];
    int            n_takes = 0;
    int            n_pops  = 0;

    assign fifo_empty     = (cnt == 5'd0);
    assign fifo_read_data = mem[rp];

    initial begin
        int            clear_seen;
        int            gen_seen;
        int            dropped;
        int            gen_left;
        logic [DW-1:0] gen_next;
        logic          pop_now;
        logic          do_wr;
        logic          do_clear;
        logic [DW-1:0] wdat;
        logic [DW-1:0] exp_word;
        clear_seen = 0;
        gen_seen   = 0;
        dropped    = 0;
        gen_left   = 0;
        gen_next   = '0;
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        forever begin
            @(negedge clk);
            while (dropped < drop_total) begin
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                dropped++;
            end
            if (gen_seen != gen_seq) begin
                gen_seen = gen_seq;
                gen_next = gen_start;
                gen_left = gen_len;
            end
            if (out_valid && out_ready) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL sb_data: got %02h, required no transfer (nothing expected)", out_data);
                end else begin
                    exp_word = exp_q.pop_front();
                    if (out_data !== exp_word) begin
                        n_bad++;
                        $display("FAIL sb_data: got %02h, required %02h (transfer %0d)", out_data, exp_word, n_takes);
                    end
                end
                n_takes++;
            end
            pop_now = fifo_read_en;
            if (pop_now && cnt == 5'd0) begin
                n_vec++;
                n_bad++;
                $display("FAIL underflow: got fifo_read_en=1, required 0 while fifo empty");
            end
            if (pop_now) n_pops++;
            do_clear   = (clear_seen != clear_seq);
            clear_seen = clear_seq;
            do_wr      = 1'b0;
            wdat       = '0;
            if (!do_clear && cnt != 5'(DEPTH)) begin
                if (wr_en) begin
                    do_wr = 1'b1;
                    wdat  = wr_data;
                end else if (gen_left > 0) begin
                    do_wr    = 1'b1;
                    wdat     = gen_next;
                    gen_next = gen_next + 8'd1;
                    gen_left--;
                end
            end
            @(posedge clk);
            if (do_clear) begin
                rp <= '0;
                wp <= '0;
                cnt <= '0;
                exp_q.delete();
                gen_left = 0;
            end else begin
                if (do_wr) begin
                    mem[wp] <= wdat;
                    wp <= wp + 4'd1;
                    exp_q.push_back(wdat);
                end
                if (pop_now && cnt != 5'd0) rp <= rp + 4'd1;
                cnt <= cnt + 5'(do_wr) - 5'(pop_now && cnt != 5'd0);
            end
        end
    end

    typedef struct {
        logic          push;
        logic [DW-1:0] data;
        logic          ready;
        logic          exp_rd_en;
        logic          exp_valid;
        logic [DW-1:0] exp_data;
        logic [CW-1:0] exp_count;
    } vec_t;

    vec_t vec [10];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", name, got, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_takes(input int target, input int budget, input string name, output int cycles);
        cycles = 0;
        while (n_takes < target && cycles < budget) begin
            step();
            cycles++;
        end
        if (n_takes < target) begin
            n_vec++;
            n_bad++;
            $display("FAIL %s: got %0d transfers, required %0d within %0d cycles", name, n_takes, target, budget);
        end
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        clear_seq = clear_seq + 1;
        step();
        reset = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, required finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        int base_p;
        int k;
        int c0;
        int dev;

        reset = 1'b0; out_ready = 1'b0; wr_en = 1'b0; wr_data = '0;
        clear_seq = 0; gen_seq = 0; gen_start = '0; gen_len = 0; drop_total = 0;

        //            push  data   ready  rd_en valid data   count
        vec[0] = '{1'b1, 8'h11, 1'b0, 1'b1, 1'b0, 8'h00, 16'd0};
        vec[1] = '{1'b1, 8'h22, 1'b0, 1'b1, 1'b1, 8'h11, 16'd0};
        vec[2] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h11, 16'd0};
        vec[3] = '{1'b1, 8'h33, 1'b0, 1'b0, 1'b1, 8'h11, 16'd0};
        vec[4] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h22, 16'd1};
        vec[5] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h33, 16'd2};
        vec[6] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h33, 16'd3};
        vec[7] = '{1'b1, 8'h44, 1'b1, 1'b1, 1'b0, 8'h33, 16'd3};
        vec[8] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h44, 16'd3};
        vec[9] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h44, 16'd4};

        // Reset held while the FIFO fills with 3 words.
        step(); step();
        for (int i = 0; i < 3; i++) begin
            wr_en = 1'b1;
            wr_data = DW'(i);
            step();
        end
        wr_en = 1'b0;
        step();
        check("rst_rd_en", 32'(fifo_read_en), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data", 32'(out_data), 32'h00);
        check("rst_count", 32'(word_count), 32'd0);
        reset = 1'b1;
        #1;
        check("rel_rd_en", 32'(fifo_read_en), 32'd1);
        step();
        check("first_valid", 32'(out_valid), 32'd1);
        check("first_data", 32'(out_data), 32'h00);
        out_ready = 1'b1;
        wait_takes(3, 20, "rst_drain", k);
        step(); step();
        check("drain_valid", 32'(out_valid), 32'd0);
        check("drain_rd_en", 32'(fifo_read_en), 32'd0);
        check("drain_count", 32'(word_count), 32'd3);
        out_ready = 1'b0;

        // Single-step table through EMPTY / ONE / FULL.
        pulse_reset();
        for (int i = 0; i < 10; i++) begin
            wr_en = vec[i].push;
            wr_data = vec[i].data;
            out_ready = vec[i].ready;
            step();
            check($sformatf("vec%0d_rd_en", i), 32'(fifo_read_en), 32'(vec[i].exp_rd_en));
            check($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(vec[i].exp_valid));
            check($sformatf("vec%0d_data", i), 32'(out_data), 32'(vec[i].exp_data));
            check($sformatf("vec%0d_count", i), 32'(word_count), 32'(vec[i].exp_count));
        end
        wr_en = 1'b0;
        out_ready = 1'b0;

        // Streaming 0..255 with constant ready.
        pulse_reset();
        base = n_takes;
        out_ready = 1'b1;
        gen_start = 8'h00; gen_len = 256; gen_seq = gen_seq + 1;
        k = 0;
        while (n_takes == base && k < 50) begin step(); k++; end
        c0 = k;
        while (n_takes < base + 256 && k < 2000) begin step(); k++; end
        check("stream_done", 32'(n_takes - base), 32'd256);
        check("stream_gap", 32'(k - c0), 32'd255);
        check("stream_count", 32'(word_count), 32'd256);
        out_ready = 1'b0;

        // Backpressure with 10 words waiting.
        pulse_reset();
        base = n_takes;
        base_p = n_pops;
        gen_start = 8'h00; gen_len = 10; gen_seq = gen_seq + 1;
        step(); step(); step();
        dev = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (out_valid !== 1'b1 || out_data !== 8'h00) dev++;
        end
        check("bp_hold", 32'(dev), 32'd0);
        check("bp_pops", 32'(n_pops - base_p), 32'd2);
        check("bp_rd_en", 32'(fifo_read_en), 32'd0);
        out_ready = 1'b1;
        wait_takes(base + 10, 40, "bp_drain", k);
        check("bp_cycles", 32'(k), 32'd10);
        check("bp_count", 32'(word_count), 32'd10);
        out_ready = 1'b0;

        // Interleaved: writer always pushes, ready on every 20th cycle.
        pulse_reset();
        base = n_takes;
        gen_start = 8'h00; gen_len = 100000; gen_seq = gen_seq + 1;
        for (int c = 0; c < 512; c++) begin
            out_ready = ((c % 20) == 19);
            step();
        end
        out_ready = 1'b0;
        check("il_takes", 32'(n_takes - base), 32'd25);
        check("il_count", 32'(word_count), 32'd25);

        // Single word then the FIFO runs empty.
        pulse_reset();
        base = n_takes;
        out_ready = 1'b1;
        wr_en = 1'b1;
        wr_data = 8'h5A;
        step();
        wr_en = 1'b0;
        wait_takes(base + 1, 10, "ee_take", k);
        step(); step();
        check("ee_valid", 32'(out_valid), 32'd0);
        check("ee_rd_en", 32'(fifo_read_en), 32'd0);
        check("ee_count", 32'(word_count), 32'd1);
        out_ready = 1'b0;

        // Reset from FULL discards the two buffered words.
        pulse_reset();
        base_p = n_pops;
        gen_start = 8'hA0; gen_len = 5; gen_seq = gen_seq + 1;
        repeat (8) step();
        check("mr_pops", 32'(n_pops - base_p), 32'd2);
        check("mr_valid_pre", 32'(out_valid), 32'd1);
        reset = 1'b0;
        #1;
        check("mr_valid_async", 32'(out_valid), 32'd0);
        check("mr_data_async", 32'(out_data), 32'h00);
        check("mr_rd_en_async", 32'(fifo_read_en), 32'd0);
        drop_total = drop_total + 2;
        step();
        reset = 1'b1;
        base = n_takes;
        out_ready = 1'b1;
        wait_takes(base + 3, 20, "mr_drain", k);
        check("mr_count", 32'(word_count), 32'd3);
        out_ready = 1'b0;
        step(); step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
